// File: rtl/smu_pkg.sv
// Shared SMU dribble definitions.
// State encoding, stack-cache sizing and pointer step.
package smu_pkg;

  localparam int SC_DEPTH     = 64;
  localparam int STALL_THRESH = 6;
  localparam int WORD_BYTES   = 4;
  localparam int MARK_W       = 6;
  localparam int NUM_W        = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SPILL_REQ = 2'd1,
    FILL_REQ  = 2'd2
  } smu_state_e;

endpackage

// File: rtl/smu_sbottom_reg.sv
// SC_BOTTOM pointer register.
// Software load beats increment, increment beats decrement.
module smu_sbottom_reg
  import smu_pkg::*;
(
  input  logic        pj_clk,
  input  logic        pj_reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        inc,
  input  logic        dec,
  output logic [31:0] sc_bottom
);

  always_ff @(posedge pj_clk) begin
    if (pj_reset)
      sc_bottom <= '0;
    else if (load)
      sc_bottom <= load_val;
    else if (inc)
      sc_bottom <= sc_bottom + 32'(WORD_BYTES);
    else if (dec)
      sc_bottom <= sc_bottom - 32'(WORD_BYTES);
  end

endmodule

// File: rtl/smu_dribble_ctl.sv
// Stack-cache dribble controller.
// Watermark spill/fill decisions and DCU request sequencing.
module smu_dribble_ctl
  import smu_pkg::*;
(
  input  logic              pj_clk,
  input  logic              pj_reset,
  input  logic [NUM_W-1:0]  num_entries,
  input  logic [MARK_W-1:0] high_mark,
  input  logic [MARK_W-1:0] low_mark,
  input  logic              und_flw,
  input  logic              ovr_flw,
  input  logic [31:0]       smu_sbase,
  input  logic              smu_sbase_we,
  input  logic              squash_fill,
  input  logic              dcu_smu_ack,
  output logic              spill,
  output logic              fill,
  output logic              dcu_smu_req,
  output logic              dcu_smu_st,
  output logic [31:0]       dcu_smu_addr,
  output logic [31:0]       sc_bottom,
  output logic              load_w,
  output logic              less_than_6,
  output logic              dribble_stall,
  output logic              cfg_err
);

  smu_state_e state_q, state_d;
  logic cfg_bad, cfg_err_q;
  logic spill_go, fill_go;
  logic ptr_inc, ptr_dec;
  logic load_w_d, load_w_q;

  assign cfg_bad = high_mark <= low_mark;

  // Invalid marks freeze new requests until reset.
  assign spill_go = (num_entries > {1'b0, high_mark})
                  & ~ovr_flw & ~cfg_bad & ~cfg_err_q;
  assign fill_go  = (num_entries < {1'b0, low_mark})
                  & ~und_flw & ~squash_fill
                  & ~cfg_bad & ~cfg_err_q;

  always_comb begin
    state_d  = state_q;
    ptr_inc  = 1'b0;
    ptr_dec  = 1'b0;
    load_w_d = 1'b0;
    if (smu_sbase_we) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (spill_go)
            state_d = SPILL_REQ;
          else if (fill_go)
            state_d = FILL_REQ;
        end
        SPILL_REQ: begin
          if (dcu_smu_ack) begin
            ptr_dec = 1'b1;
            state_d = IDLE;
          end
        end
        FILL_REQ: begin
          if (dcu_smu_ack) begin
            ptr_inc  = 1'b1;
            load_w_d = ~squash_fill;
            state_d  = IDLE;
          end else if (squash_fill) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pj_clk) begin
    if (pj_reset) begin
      state_q   <= IDLE;
      load_w_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_w_q  <= load_w_d;
      cfg_err_q <= cfg_err_q | cfg_bad;
    end
  end

  smu_sbottom_reg u_sbottom (
    .pj_clk    (pj_clk),
    .pj_reset  (pj_reset),
    .load      (smu_sbase_we),
    .load_val  (smu_sbase),
    .inc       (ptr_inc),
    .dec       (ptr_dec),
    .sc_bottom (sc_bottom)
  );

  assign spill        = state_q == SPILL_REQ;
  assign fill         = state_q == FILL_REQ;
  assign dcu_smu_req  = spill | fill;
  assign dcu_smu_st   = spill;
  assign dcu_smu_addr = fill ? sc_bottom + 32'(WORD_BYTES)
                             : sc_bottom;
  assign load_w        = load_w_q;
  assign cfg_err       = cfg_err_q;
  assign less_than_6   = num_entries < NUM_W'(STALL_THRESH);
  assign dribble_stall = less_than_6 & ~und_flw;

endmodule

// File: tb/tb_smu_dribble_ctl.sv
// Bench for smu_dribble_ctl.
// Directed scenarios then random traffic against a request-level model.
module tb_smu_dribble_ctl;

  logic        pj_clk = 1'b0;
  logic        pj_reset;
  logic [6:0]  num_entries;
  logic [5:0]  high_mark, low_mark;
  logic        und_flw, ovr_flw;
  logic [31:0] smu_sbase;
  logic        smu_sbase_we, squash_fill, dcu_smu_ack;
  logic        spill, fill, dcu_smu_req, dcu_smu_st;
  logic [31:0] dcu_smu_addr, sc_bottom;
  logic        load_w, less_than_6, dribble_stall, cfg_err;

  int n_chk = 0;
  int n_pass = 0;

  // Model: one outstanding request (kind + pointer) plus flags.
  bit          m_req, m_st, m_loadw, m_cfg;
  logic [31:0] m_bot;
  int          ne;

  always #5 pj_clk = ~pj_clk;

  smu_dribble_ctl dut (
    .pj_clk        (pj_clk),
    .pj_reset      (pj_reset),
    .num_entries   (num_entries),
    .high_mark     (high_mark),
    .low_mark      (low_mark),
    .und_flw       (und_flw),
    .ovr_flw       (ovr_flw),
    .smu_sbase     (smu_sbase),
    .smu_sbase_we  (smu_sbase_we),
    .squash_fill   (squash_fill),
    .dcu_smu_ack   (dcu_smu_ack),
    .spill         (spill),
    .fill          (fill),
    .dcu_smu_req   (dcu_smu_req),
    .dcu_smu_st    (dcu_smu_st),
    .dcu_smu_addr  (dcu_smu_addr),
    .sc_bottom     (sc_bottom),
    .load_w        (load_w),
    .less_than_6   (less_than_6),
    .dribble_stall (dribble_stall),
    .cfg_err       (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    logic [31:0] nb;
    bit nr, ns, nl, nc;
    #1;
    chk("req", dcu_smu_req, m_req);
    chk("st", dcu_smu_st, m_req && m_st);
    chk("spill", spill, m_req && m_st);
    chk("fill", fill, m_req && !m_st);
    if (m_req)
      chk("addr", dcu_smu_addr, m_st ? m_bot : m_bot + 4);
    chk("bottom", sc_bottom, m_bot);
    chk("load_w", load_w, m_loadw);
    chk("cfg_err", cfg_err, m_cfg);
    chk("lt6", less_than_6, ne < 6);
    chk("dstall", dribble_stall, (ne < 6) && !und_flw);
    nb = m_bot; nr = m_req; ns = m_st; nl = 0; nc = m_cfg;
    if (pj_reset) begin
      nb = 0; nr = 0; ns = 0; nc = 0;
    end else begin
      if (smu_sbase_we) begin
        nb = smu_sbase; nr = 0;
      end else if (m_req) begin
        if (dcu_smu_ack) begin
          nb = m_st ? m_bot - 4 : m_bot + 4;
          nl = !m_st && !squash_fill;
          nr = 0;
        end else if (!m_st && squash_fill) begin
          nr = 0;
        end
      end else if (!m_cfg && int'(high_mark) > int'(low_mark)) begin
        if (ne > int'(high_mark) && !ovr_flw) begin
          nr = 1; ns = 1;
        end else if (ne < int'(low_mark) && !und_flw && !squash_fill) begin
          nr = 1; ns = 0;
        end
      end
      if (int'(high_mark) <= int'(low_mark)) nc = 1;
    end
    @(posedge pj_clk);
    m_bot = nb; m_req = nr; m_st = ns; m_loadw = nl; m_cfg = nc;
    @(negedge pj_clk);
  endtask

  task automatic cyc(input int n, input bit a, input bit s,
                     input bit w, input logic [31:0] b, input bit r);
    ne = n;
    num_entries  = 7'(n);
    dcu_smu_ack  = a;
    squash_fill  = s;
    smu_sbase_we = w;
    smu_sbase    = b;
    pj_reset     = r;
    step();
  endtask

  initial begin
    pj_reset = 1; num_entries = 0; ne = 0;
    high_mark = 6'd48; low_mark = 6'd8;
    und_flw = 0; ovr_flw = 0; smu_sbase = 0;
    smu_sbase_we = 0; squash_fill = 0; dcu_smu_ack = 0;
    m_req = 0; m_st = 0; m_loadw = 0; m_cfg = 0; m_bot = 0;
    repeat (2) @(posedge pj_clk);
    @(negedge pj_clk);
    cyc(30, 0, 0, 0, 0, 1);

    // Spill at 0x1000, ack on third request cycle.
    cyc(30, 0, 0, 1, 32'h1000, 0);
    cyc(50, 0, 0, 0, 0, 0);
    chk("t1_addr", dcu_smu_addr, 32'h1000);
    chk("t1_spill", spill, 1);
    cyc(50, 0, 0, 0, 0, 0);
    cyc(50, 1, 0, 0, 0, 0);
    chk("t1_bot", sc_bottom, 32'h0FFC);
    chk("t1_idle", dcu_smu_req, 0);

    // Fill with immediate ack.
    cyc(5, 0, 0, 0, 0, 0);
    chk("t2_lt6", less_than_6, 1);
    chk("t2_dstall", dribble_stall, 1);
    chk("t2_addr", dcu_smu_addr, 32'h1000);
    chk("t2_fill", fill, 1);
    cyc(5, 1, 0, 0, 0, 0);
    chk("t2_bot", sc_bottom, 32'h1000);
    chk("t2_lw", load_w, 1);
    cyc(30, 0, 0, 0, 0, 0);
    chk("t2_lw_off", load_w, 0);

    // Squashed fill.
    cyc(5, 0, 0, 0, 0, 0);
    cyc(5, 0, 1, 0, 0, 0);
    chk("t3_req", dcu_smu_req, 0);
    chk("t3_bot", sc_bottom, 32'h1000);
    cyc(30, 0, 0, 0, 0, 0);
    chk("t3_lw", load_w, 0);

    // Software write coincident with spill ack.
    cyc(50, 0, 0, 0, 0, 0);
    cyc(30, 1, 0, 1, 32'h2000, 0);
    chk("t4_bot", sc_bottom, 32'h2000);
    chk("t4_req", dcu_smu_req, 0);

    // Reset mid-spill, late ack.
    cyc(50, 0, 0, 0, 0, 0);
    cyc(50, 0, 0, 0, 0, 1);
    cyc(30, 1, 0, 0, 0, 0);
    chk("t6_bot", sc_bottom, 0);
    chk("t6_req", dcu_smu_req, 0);

    // Inverted marks.
    high_mark = 6'd4; low_mark = 6'd10;
    for (int i = 0; i < 8; i++) begin
      cyc((i % 2) ? 50 : 2, 0, 0, 0, 0, 0);
      chk("t5_req", dcu_smu_req, 0);
    end
    high_mark = 6'd48; low_mark = 6'd8;
    cyc(50, 0, 0, 0, 0, 0);
    chk("t5_sticky", cfg_err, 1);
    chk("t5_noreq", dcu_smu_req, 0);
    cyc(30, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        high_mark = 6'($urandom);
        low_mark  = 6'($urandom);
      end else if ($urandom_range(99) < 5) begin
        high_mark = 6'($urandom_range(30, 60));
        low_mark  = 6'($urandom_range(4, 20));
      end
      und_flw = $urandom_range(99) < 15;
      ovr_flw = $urandom_range(99) < 15;
      cyc($urandom_range(0, 64),
          $urandom_range(99) < 40,
          $urandom_range(99) < 10,
          $urandom_range(99) < 4,
          $urandom & 32'hFFFF_FFFC,
          $urandom_range(99) < 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/smu_dribble_ctl.md
Name: smu_dribble_ctl

Overview:
- Stack-management-unit dribble controller for the 64-entry stack cache (S$).
- Compares S$ occupancy against the programmed high/low watermarks and decides when to spill (S$ → D$ store) or fill (D$ → S$ load), one word at a time.
- Sequences the DCU request/ack handshake and owns the SC_BOTTOM pointer.
- Sits between the IU stack-cache datapath (RCU) and the DCU; drives the spill/fill/dribble_stall signals that the SMU checkers monitor.

Parameters:
- SC_DEPTH, 64, S$ entries; num_entries is 0..SC_DEPTH.
- STALL_THRESH, 6, below this many entries the IU is stalled until a fill completes.
- WORD_BYTES, 4, SC_BOTTOM step per spill/fill.

Ports:
- pj_clk  in  1  clock.
- pj_reset  in  1  synchronous, active-high reset.
- num_entries  in  7  current S$ occupancy, from optop/SC_BOTTOM difference.
- high_mark  in  6  spill watermark (PSR/SC config).
- low_mark  in  6  fill watermark.
- und_flw  in  1  SC_BOTTOM at stack base; no data in memory to fill.
- ovr_flw  in  1  stack limit reached; spilling disabled.
- smu_sbase  in  32  software-written SC_BOTTOM value.
- smu_sbase_we  in  1  load smu_sbase into SC_BOTTOM.
- squash_fill  in  1  cancel the pending/outstanding fill (optop write).
- dcu_smu_ack  in  1  DCU accepted the current request.
- spill  out  1  spill request active (registered).
- fill  out  1  fill request active (registered).
- dcu_smu_req  out  1  request valid to DCU.
- dcu_smu_st  out  1  1 = store (spill), 0 = load (fill); valid with req.
- dcu_smu_addr  out  32  word address for the request.
- sc_bottom  out  32  current SC_BOTTOM pointer.
- load_w  out  1  one-cycle pulse: fill data valid, write S$ bottom entry.
- less_than_6  out  1  num_entries < STALL_THRESH.
- dribble_stall  out  1  less_than_6 & ~und_flw.
- cfg_err  out  1  sticky: high_mark <= low_mark seen.

Behaviour:
- Reset: all outputs 0, sc_bottom = 0, FSM = IDLE, cfg_err = 0. Reset mid-request drops req at the next edge; any later ack is ignored.
- FSM states: IDLE, SPILL_REQ, FILL_REQ.
- IDLE → SPILL_REQ when num_entries > high_mark & ~ovr_flw & ~cfg condition.
- IDLE → FILL_REQ when num_entries < low_mark & ~und_flw & ~squash_fill.
- Spill has priority only if both are ever true; the mark check makes this unreachable when the configuration is valid.
- If high_mark <= low_mark: no new request is issued, cfg_err is set sticky (clear only by reset).
- SPILL_REQ:
  - req = 1, st = 1, addr = sc_bottom; spill = 1.
  - Held stable until ack.
  - On ack: sc_bottom <= sc_bottom − 4; go to IDLE.
- FILL_REQ:
  - req = 1, st = 0, addr = sc_bottom + 4; fill = 1.
  - On ack: sc_bottom <= sc_bottom + 4; load_w pulses for exactly 1 cycle in the ack cycle + 1; go to IDLE.
- Throughput: one request per 2 cycles minimum (ack cycle, then IDLE re-evaluates). Latency from watermark crossing to req = 1 cycle.
- squash_fill:
  - In FILL_REQ before ack: drop req next cycle, return to IDLE, no pointer change, no load_w.
  - In the ack cycle: pointer still updates, load_w suppressed.
- smu_sbase_we: highest priority. sc_bottom <= smu_sbase; FSM → IDLE; req dropped. An ack in the same cycle is ignored for pointer/load_w.
- spill and fill are never both 1 (one-hot state decode).
- Address arithmetic is 32-bit modulo; wrap at 0 or 0xFFFFFFFC is not trapped (ovr_flw/und_flw guard upstream).
- less_than_6 and dribble_stall are combinational from num_entries/und_flw.

Decomposition:
- Shared package smu_pkg:
  - FSM state encoding (2-bit).
  - SC_DEPTH, STALL_THRESH, WORD_BYTES.
  - Watermark width constant.
- One sub-module: smu_sbottom_reg (32-bit pointer with load / +4 / −4 controls and priority mux). FSM and handshake stay in the top.

Test Plan:
- high_mark=48, low_mark=8, sbase write 0x1000, num_entries=50, ack after 2 cycles → one store at addr 0x1000, spill=1 three cycles, then sc_bottom=0x0FFC.
- num_entries=5, und_flw=0, sc_bottom=0x0FFC, ack immediate → less_than_6=1, dribble_stall=1, load at 0x1000, load_w single pulse, sc_bottom=0x1000.
- Fill pending, squash_fill asserted before ack → req drops next cycle, sc_bottom unchanged, no load_w.
- smu_sbase_we=1 (0x2000) coincident with spill ack → sc_bottom=0x2000, FSM IDLE, ack ignored.
- high_mark=4, low_mark=10 → cfg_err=1, no req ever asserted until reset.
- Reset asserted in SPILL_REQ, ack arrives one cycle later → req=0, sc_bottom=0, no state change from the late ack.
